// File: rtl/instr_fetch_sequencer_pkg.sv
// Shared types and constants for the byte-wise instruction fetch sequencer.
package instr_fetch_sequencer_pkg;

  localparam int unsigned IR_BYTES = 4;
  localparam int unsigned PC_STEP  = 4;
  localparam int unsigned TAG_W    = 2;

  localparam logic [IR_BYTES-1:0] BE_NONE = 4'b0000;
  localparam logic [IR_BYTES-1:0] BE_B0   = 4'b0001;
  localparam logic [IR_BYTES-1:0] BE_B1   = 4'b0010;
  localparam logic [IR_BYTES-1:0] BE_B2   = 4'b0100;
  localparam logic [IR_BYTES-1:0] BE_B3   = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // Byte index to one-hot IR byte enable.
  function automatic logic [IR_BYTES-1:0] byte_en(input logic [TAG_W-1:0] tag);
    case (tag)
      2'd0:    return BE_B0;
      2'd1:    return BE_B1;
      2'd2:    return BE_B2;
      default: return BE_B3;
    endcase
  endfunction

endpackage

// File: rtl/instr_fetch_sequencer_if.sv
// Fetch request / memory / IR handshake bundle between main control and the sequencer.
interface instr_fetch_sequencer_if #(
  parameter int unsigned ADDR_W = 8
) ();

  logic              start;
  logic [ADDR_W-1:0] pcIn;
  logic [ADDR_W-1:0] memAddr;
  logic              memRead;
  logic [3:0]        irEn;
  logic              busy;
  logic              done;
  logic              pcWrite;
  logic [ADDR_W-1:0] pcNext;

  modport master (
    output start, pcIn,
    input  memAddr, memRead, irEn, busy, done, pcWrite, pcNext
  );

  modport slave (
    input  start, pcIn,
    output memAddr, memRead, irEn, busy, done, pcWrite, pcNext
  );

endinterface

// File: rtl/instr_fetch_sequencer_fetch_tag_pipe.sv
// Delays each issued byte tag by the memory latency and decodes it into the IR byte enable.
module instr_fetch_sequencer_fetch_tag_pipe
  import instr_fetch_sequencer_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                i_valid,
  input  logic [TAG_W-1:0]    i_tag,
  output logic [IR_BYTES-1:0] o_ir_en
);

  logic             w_valid;
  logic [TAG_W-1:0] w_tag;

  generate
    if (MEM_LAT == 0) begin : g_bypass
      logic w_unused_clk;
      assign w_unused_clk = clock ^ resetn;
      assign w_valid      = i_valid;
      assign w_tag        = i_tag;
    end else begin : g_pipe
      logic [MEM_LAT-1:0] r_valid;
      logic [TAG_W-1:0]   r_tag [MEM_LAT];

      always_ff @(posedge clock) begin
        if (!resetn) begin
          r_valid <= '0;
          for (int i = 0; i < int'(MEM_LAT); i++) r_tag[i] <= '0;
        end else begin
          r_valid[0] <= i_valid;
          r_tag[0]   <= i_tag;
          for (int i = 1; i < int'(MEM_LAT); i++) begin
            r_valid[i] <= r_valid[i-1];
            r_tag[i]   <= r_tag[i-1];
          end
        end
      end

      assign w_valid = r_valid[MEM_LAT-1];
      assign w_tag   = r_tag[MEM_LAT-1];
    end
  endgenerate

  assign o_ir_en = w_valid ? byte_en(w_tag) : BE_NONE;

endmodule

// File: rtl/instr_fetch_sequencer.sv
// Sequences four byte reads at pc..pc+3, steers each returning byte into the IR and posts pc+4.
module instr_fetch_sequencer
  import instr_fetch_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned MEM_LAT = 1
) (
  input logic                    clock,
  input logic                    resetn,
  instr_fetch_sequencer_if.slave bus
);

  localparam int unsigned DRAIN_LAST = (MEM_LAT > 0) ? MEM_LAT - 1 : 0;

  state_e              r_state;
  logic [ADDR_W-1:0]   r_base;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [ADDR_W-1:0]   r_pc_next;
  logic [TAG_W-1:0]    r_issue_cnt;
  logic [1:0]          r_drain_cnt;
  logic                r_mem_read;
  logic                r_busy;
  logic                r_done;
  logic                r_pc_write;
  logic [IR_BYTES-1:0] w_ir_en;

  // r_issue_cnt always holds the byte index of the address currently on memAddr.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_base      <= '0;
      r_mem_addr  <= '0;
      r_pc_next   <= '0;
      r_issue_cnt <= '0;
      r_drain_cnt <= '0;
      r_mem_read  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pc_write  <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_pc_write <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_state     <= ST_ISSUE;
            r_base      <= bus.pcIn;
            r_mem_addr  <= bus.pcIn;
            r_mem_read  <= 1'b1;
            r_issue_cnt <= '0;
            r_busy      <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (r_issue_cnt == TAG_W'(IR_BYTES - 1)) begin
            r_mem_read <= 1'b0;
            if (MEM_LAT > 0) begin
              r_state     <= ST_DRAIN;
              r_drain_cnt <= 2'(DRAIN_LAST);
            end else begin
              r_state    <= ST_DONE;
              r_done     <= 1'b1;
              r_pc_write <= 1'b1;
              r_pc_next  <= r_base + ADDR_W'(PC_STEP);
            end
          end else begin
            r_issue_cnt <= r_issue_cnt + TAG_W'(1);
            r_mem_addr  <= r_base + ADDR_W'(r_issue_cnt) + ADDR_W'(1);
          end
        end
        ST_DRAIN: begin
          if (r_drain_cnt == 2'd0) begin
            r_state    <= ST_DONE;
            r_done     <= 1'b1;
            r_pc_write <= 1'b1;
            r_pc_next  <= r_base + ADDR_W'(PC_STEP);
          end else begin
            r_drain_cnt <= r_drain_cnt - 2'd1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  instr_fetch_sequencer_fetch_tag_pipe #(
    .MEM_LAT (MEM_LAT)
  ) u_tag_pipe (
    .clock   (clock),
    .resetn  (resetn),
    .i_valid (r_mem_read),
    .i_tag   (r_issue_cnt),
    .o_ir_en (w_ir_en)
  );

  assign bus.memAddr = r_mem_addr;
  assign bus.memRead = r_mem_read;
  assign bus.irEn    = w_ir_en;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.pcWrite = r_pc_write;
  assign bus.pcNext  = r_pc_next;

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Directed bench for the fetch sequencer at MEM_LAT 0, 1 and 3 with a scoreboard on the MEM_LAT=1 unit.
module tb_instr_fetch_sequencer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic rstn1;
  logic rstn03;

  instr_fetch_sequencer_if #(.ADDR_W(8)) b0 ();
  instr_fetch_sequencer_if #(.ADDR_W(8)) b1 ();
  instr_fetch_sequencer_if #(.ADDR_W(8)) b3 ();

  instr_fetch_sequencer #(.ADDR_W(8), .MEM_LAT(0)) u_dut0 (.clock(clock), .resetn(rstn03), .bus(b0.slave));
  instr_fetch_sequencer #(.ADDR_W(8), .MEM_LAT(1)) u_dut1 (.clock(clock), .resetn(rstn1),  .bus(b1.slave));
  instr_fetch_sequencer #(.ADDR_W(8), .MEM_LAT(3)) u_dut3 (.clock(clock), .resetn(rstn03), .bus(b3.slave));

  typedef struct packed {
    logic       mem_read;
    logic [7:0] mem_addr;
    logic [3:0] ir_en;
    logic       busy;
    logic       done;
    logic       pc_write;
    logic [7:0] pc_next;
  } obs_t;

  obs_t o0, o1, o3;
  assign o0 = {b0.memRead, b0.memAddr, b0.irEn, b0.busy, b0.done, b0.pcWrite, b0.pcNext};
  assign o1 = {b1.memRead, b1.memAddr, b1.irEn, b1.busy, b1.done, b1.pcWrite, b1.pcNext};
  assign o3 = {b3.memRead, b3.memAddr, b3.irEn, b3.busy, b3.done, b3.pcWrite, b3.pcNext};

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [256];
  logic [7:0]  q_addr [$];
  logic [3:0]  q_en   [$];
  logic [7:0]  q_pc   [$];
  logic [31:0] q_ir   [$];
  logic [7:0]  f_addr [$];
  logic [31:0] ir_model = 32'h0;
  logic [7:0]  mon_a;
  int          done_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic obs_t get_obs(input int sel);
    case (sel)
      0:       return o0;
      3:       return o3;
      default: return o1;
    endcase
  endfunction

  task automatic drive(input int sel, input logic s, input logic [7:0] pc);
    case (sel)
      0: begin b0.start = s; b0.pcIn = pc; end
      3: begin b3.start = s; b3.pcIn = pc; end
      default: begin b1.start = s; b1.pcIn = pc; end
    endcase
  endtask

  task automatic push_fetch(input logic [7:0] pc);
    for (int k = 0; k < 4; k++) begin
      q_addr.push_back(8'(pc + 8'(k)));
      q_en.push_back(4'(1 << k));
    end
    q_pc.push_back(8'(pc + 8'd4));
    q_ir.push_back({mem[8'(pc + 8'd3)], mem[8'(pc + 8'd2)], mem[8'(pc + 8'd1)], mem[pc]});
  endtask

  // Scoreboard on the MEM_LAT=1 unit: address order, byte-enable order, IR assembly, pcNext.
  always @(negedge clock) begin
    if (b1.irEn !== 4'b0000) begin
      chk("ir_en_onehot", 32'($onehot(b1.irEn)), 32'd1);
      if (q_en.size() == 0) chk("ir_en_unexpected", 32'(b1.irEn), 32'd0);
      else                  chk("ir_en_order", 32'(b1.irEn), 32'(q_en.pop_front()));
      if (f_addr.size() != 0) begin
        mon_a = f_addr.pop_front();
        for (int k = 0; k < 4; k++)
          if (b1.irEn[k]) ir_model[8*k +: 8] = mem[mon_a];
      end
    end
    if (b1.memRead === 1'b1) begin
      if (q_addr.size() == 0) chk("mem_read_unexpected", 32'(b1.memAddr), 32'h100);
      else                    chk("mem_addr_order", 32'(b1.memAddr), 32'(q_addr.pop_front()));
      f_addr.push_back(b1.memAddr);
    end
    if (b1.done === 1'b1) begin
      done_cnt++;
      chk("pc_write_with_done", 32'(b1.pcWrite), 32'd1);
      if (q_pc.size() == 0) chk("done_unexpected", 32'(b1.pcNext), 32'h100);
      else                  chk("pc_next", 32'(b1.pcNext), 32'(q_pc.pop_front()));
      if (q_ir.size() != 0) chk("ir_content", ir_model, q_ir.pop_front());
    end
  end

  // One fetch with cycle-exact expectations; disturb re-asserts start mid-fetch and in DONE.
  task automatic run_fetch(input int sel, input int lat, input logic [7:0] pc, input bit disturb);
    obs_t       o;
    logic [3:0] een;
    logic [7:0] ea;
    drive(sel, 1'b1, pc);
    if (sel == 1) push_fetch(pc);
    for (int c = 1; c <= 6 + lat; c++) begin
      @(negedge clock);
      if (disturb && (c == 2 || c == 5 + lat)) drive(sel, 1'b1, 8'h80);
      else                                     drive(sel, 1'b0, 8'h80);
      o   = get_obs(sel);
      een = (c >= 1 + lat && c <= 4 + lat) ? 4'(1 << (c - 1 - lat)) : 4'b0000;
      ea  = (c <= 4) ? 8'(pc + 8'(c - 1)) : 8'(pc + 8'd3);
      chk($sformatf("L%0d_c%0d_mem_read", lat, c), 32'(o.mem_read), 32'(c <= 4));
      if (c <= 4 + lat) chk($sformatf("L%0d_c%0d_mem_addr", lat, c), 32'(o.mem_addr), 32'(ea));
      chk($sformatf("L%0d_c%0d_ir_en", lat, c), 32'(o.ir_en), 32'(een));
      chk($sformatf("L%0d_c%0d_busy", lat, c), 32'(o.busy), 32'(c <= 5 + lat));
      chk($sformatf("L%0d_c%0d_done", lat, c), 32'(o.done), 32'(c == 5 + lat));
      chk($sformatf("L%0d_c%0d_pc_write", lat, c), 32'(o.pc_write), 32'(c == 5 + lat));
      if (c == 5 + lat) chk($sformatf("L%0d_pc_next", lat), 32'(o.pc_next), 32'(8'(pc + 8'd4)));
    end
  endtask

  initial begin
    obs_t o;
    int   d0;
    for (int a = 0; a < 256; a++) mem[a] = 8'(a) ^ 8'h5A;
    mem[8'h10] = 8'h12; mem[8'h11] = 8'h34; mem[8'h12] = 8'h56; mem[8'h13] = 8'h78;

    rstn1 = 1'b0; rstn03 = 1'b0;
    drive(0, 1'b0, 8'h00); drive(1, 1'b0, 8'h00); drive(3, 1'b0, 8'h00);
    repeat (3) @(negedge clock);
    chk("reset_lat0", 32'(get_obs(0)), 32'd0);
    chk("reset_lat1", 32'(get_obs(1)), 32'd0);
    chk("reset_lat3", 32'(get_obs(3)), 32'd0);
    rstn1 = 1'b1; rstn03 = 1'b1;
    @(negedge clock);

    run_fetch(1, 1, 8'h10, 1'b0);
    chk("basic_ir_word", ir_model, 32'h78563412);
    @(negedge clock);

    run_fetch(1, 1, 8'hFE, 1'b0);
    chk("wrap_pc_next_held", 32'(b1.pcNext), 32'h02);
    @(negedge clock);

    run_fetch(1, 1, 8'h20, 1'b1);
    @(negedge clock);
    o = get_obs(1);
    chk("ignored_start_busy", 32'(o.busy), 32'd0);
    chk("ignored_start_read", 32'(o.mem_read), 32'd0);

    // start held high: fetches accepted at edges 0, 7, 14
    drive(1, 1'b1, 8'h30);
    for (int n = 0; n < 3; n++) push_fetch(8'h30);
    d0 = done_cnt;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clock);
      if (c == 20) drive(1, 1'b0, 8'h30);
      chk($sformatf("held_c%0d_mem_read", c), 32'(b1.memRead), 32'(c <= 20 && (c % 7) >= 1 && (c % 7) <= 4));
      chk($sformatf("held_c%0d_done", c), 32'(b1.done), 32'(c <= 20 && (c % 7) == 6));
    end
    chk("held_done_count", 32'(done_cnt - d0), 32'd3);

    // reset asserted during cycle 3 of a fetch
    drive(1, 1'b1, 8'h50);
    q_addr.push_back(8'h50); q_addr.push_back(8'h51); q_addr.push_back(8'h52);
    q_en.push_back(4'b0001); q_en.push_back(4'b0010);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clock);
      drive(1, 1'b0, 8'h50);
      if (c == 3) rstn1 = 1'b0;
      if (c == 4) rstn1 = 1'b1;
      if (c == 6) f_addr.delete();
      if (c >= 4) chk($sformatf("rst_mid_c%0d", c), 32'(get_obs(1)), 32'd0);
    end
    run_fetch(1, 1, 8'h60, 1'b0);
    repeat (2) @(negedge clock);
    chk("sb_drained", 32'(q_addr.size() + q_en.size() + q_pc.size() + q_ir.size()), 32'd0);

    run_fetch(0, 0, 8'h40, 1'b0);
    run_fetch(3, 3, 8'h40, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_sequencer.md
Name: instr_fetch_sequencer

Overview:
- Controller that sequences the 4-cycle byte-wise instruction fetch for the 8-bit multicycle MIPS datapath.
- On a fetch request from main control, issues four byte reads from the byte-wide memory at pc, pc+1, pc+2, pc+3.
- Drives the instruction register's one-hot byte enables so each byte lands as its data returns.
- When the fetch completes, posts pc+4 back to the PC register.

Parameters:
- ADDR_W, 8: width of PC and memory byte address.
- MEM_LAT, 1: memory read latency in cycles from address to valid data. Legal range 0..3.

Ports:
- clock   in   1       : single system clock, rising edge.
- resetn  in   1       : synchronous, active-low reset.
- start   in   1       : fetch request from main control. Sampled only in IDLE.
- pcIn    in   ADDR_W  : current PC. Captured as base address when start is accepted.
- memAddr out  ADDR_W  : byte address to instruction memory.
- memRead out  1       : memory read strobe. High while memAddr is valid.
- irEn    out  4       : one-hot IR byte enable. irEn[k] loads Instr[8k+7:8k].
- busy    out  1       : high in every state except IDLE.
- done    out  1       : one-cycle pulse when all 4 bytes have been loaded.
- pcWrite out  1       : one-cycle PC load strobe, coincident with done.
- pcNext  out  ADDR_W  : base+4 mod 2^ADDR_W. Valid when pcWrite is high.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low. resetn is sampled on the rising edge of clock.
- Reset values: state=IDLE; memAddr=0, memRead=0, irEn=0, busy=0, done=0, pcWrite=0, pcNext=0; issue counter, return counter and latency tag pipe all cleared.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - Outputs low.
  - start=1 at an edge: base<=pcIn, issueCnt<=0, go to ISSUE.
- ISSUE (exactly 4 cycles):
  - memRead=1, memAddr=base+issueCnt (mod 2^ADDR_W); issueCnt increments each cycle.
  - Each issue pushes tag k into a MEM_LAT-deep delay line.
  - After issueCnt=3: go to DRAIN if MEM_LAT>0, else to DONE.
- DRAIN (MEM_LAT cycles): memRead=0, memAddr holds its last value.
- irEn timing:
  - irEn[k]=1 in the cycle when byte k's data is valid, i.e. MEM_LAT cycles after its address cycle.
  - MEM_LAT=0: irEn[k] is asserted in the same cycle as address k.
  - irEn is never multi-hot.
- DONE (1 cycle): done=1, pcWrite=1, pcNext=base+4. Unconditionally returns to IDLE.
- Latency: start accepted at edge 0; ISSUE occupies cycles 1..4; irEn is active in cycles 1+MEM_LAT..4+MEM_LAT; DONE is cycle 5+MEM_LAT.
- Byte order: byte at base+k goes to IR byte k. Memory bytes 12,34,56,78 produce Instr=32'h78563412.
- Wrap-around: address and pcNext arithmetic are modulo 2^ADDR_W. base=8'hFE issues FE,FF,00,01 and gives pcNext=8'h02.
- start outside IDLE (including the DONE cycle): ignored, not queued. Main control must reassert it.
- start held high continuously: a new fetch begins on the edge after DONE, giving back-to-back fetches with one IDLE cycle between them.
- pcIn changing mid-fetch: no effect; base is latched.
- Reset mid-operation: resetn=0 at any edge forces reset values on the next cycle. In-flight tags are discarded, no further irEn is issued, and no done or pcWrite is produced.

Decomposition:
- Shared package:
  - state enum (IDLE, ISSUE, DRAIN, DONE);
  - IR_BYTES=4;
  - PC_STEP=4;
  - one-hot byte-enable constants.
- Sub-module fetch_tag_pipe:
  - MEM_LAT-deep valid+2-bit-tag shift register;
  - outputs the decoded one-hot irEn;
  - synchronous active-low clear;
  - MEM_LAT=0 is a combinational pass-through.

Test Plan:
- Basic fetch, MEM_LAT=1, pcIn=8'h10, start pulse in IDLE:
  - memAddr 10,11,12,13 with memRead high in cycles 1..4;
  - irEn 0001,0010,0100,1000 in cycles 2..5;
  - done=pcWrite=1 with pcNext=8'h14 in cycle 6;
  - with memory bytes 12,34,56,78 the IR holds 32'h78563412.
- Wrap, pcIn=8'hFE -> addresses FE,FF,00,01; pcNext=8'h02.
- start pulses in cycles 2 and 6 of an active fetch, and pcIn changed mid-fetch -> single fetch only; addresses unaffected; busy remains 1 until DONE.
- start held high for 20 cycles, MEM_LAT=1 -> a fetch every 7 cycles; exactly one done per fetch; irEn is never multi-hot.
- resetn=0 in cycle 3 of a fetch -> all outputs 0 from next cycle; no irEn[2], irEn[3], done or pcWrite; a later start fetches normally.
- MEM_LAT=0 and MEM_LAT=3 builds, pcIn=8'h40:
  - MEM_LAT=0: irEn aligned with address cycles 1..4, done in cycle 5;
  - MEM_LAT=3: irEn in cycles 4..7, done in cycle 8.
